rob_param: RTL

- Parametrised reorder buffer. Tracks in-flight instructions in program order between dispatch and retire.
- Holds per-entry state (Free/Pending/Finished), speculative bit, store bit, destination-valid bit and physical destination register.
- Supports out-of-order completion by tag, in-order commit from the head, and squash of speculative entries on branch mispredict.
- Sits between rename/dispatch and the retire/PRF-free logic.

---
 rtl/rob_param.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/rob_param.sv
// Reorder buffer: in-order allocate/commit with out-of-order completion by tag and mispredict squash.
// Commit outputs are combinational from the head entry; alloc_ready drops when full or during a mispredict.
module rob_param #(
  parameter int  DEPTH  = 8,
  parameter int  PREG_W = 5,
  localparam int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc_valid,
  output logic              alloc_ready,
  input  logic              alloc_spec,
  input  logic              alloc_store,
  input  logic              alloc_pdst_v,
  input  logic [PREG_W-1:0] alloc_pdst,
  output logic [IDX_W-1:0]  alloc_tag,
  input  logic              cmpl_valid,
  input  logic [IDX_W-1:0]  cmpl_tag,
  output logic              commit_valid,
  input  logic              commit_ready,
  output logic [IDX_W-1:0]  commit_tag,
  output logic              commit_store,
  output logic              commit_pdst_v,
  output logic [PREG_W-1:0] commit_pdst,
  input  logic              resolve_valid,
  input  logic              resolve_ok,
  output logic [IDX_W:0]    count,
  output logic              full,
  output logic              empty
);

  typedef enum logic [1:0] {
    ST_FREE = 2'b00,
    ST_PEND = 2'b01,
    ST_FIN  = 2'b10
  } state_e;

  state_e            state_q [DEPTH];
  state_e            state_d [DEPTH];
  logic [PREG_W-1:0] pdst_q  [DEPTH];
  logic [PREG_W-1:0] pdst_d  [DEPTH];
  logic [DEPTH-1:0]  spec_q, spec_d;
  logic [DEPTH-1:0]  store_q, store_d;
  logic [DEPTH-1:0]  pdv_q, pdv_d;
  logic [IDX_W-1:0]  head_q, head_d;
  logic [IDX_W-1:0]  tail_q, tail_d;
  logic [IDX_W:0]    count_q, count_d;

  logic             mispredict, alloc_fire, commit_fire;
  logic             sq_found, squash;
  logic [IDX_W-1:0] sq_off, sq_idx;
  logic [IDX_W:0]   sq_num;

  assign full        = (count_q == (IDX_W+1)'(DEPTH));
  assign empty       = (count_q == '0);
  assign count       = count_q;
  assign mispredict  = resolve_valid & ~resolve_ok;
  assign alloc_ready = ~full & ~mispredict;
  assign alloc_fire  = alloc_valid & alloc_ready;
  assign alloc_tag   = tail_q;

  // Gated by rst so a reset cycle never retires anything.
  assign commit_valid  = rst & ~empty & (state_q[head_q] == ST_FIN) & ~spec_q[head_q];
  assign commit_fire   = commit_valid & commit_ready;
  assign commit_tag    = head_q;
  assign commit_store  = store_q[head_q];
  assign commit_pdst_v = pdv_q[head_q];
  assign commit_pdst   = pdst_q[head_q];

  // Backward scan so the last hit is the oldest speculative entry.
  always_comb begin
    sq_found = 1'b0;
    sq_off   = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (((IDX_W+1)'(i) < count_q) && spec_q[head_q + IDX_W'(i)]) begin
        sq_found = 1'b1;
        sq_off   = IDX_W'(i);
      end
    end
  end

  assign squash = mispredict & sq_found;
  assign sq_idx = head_q + sq_off;
  assign sq_num = count_q - {1'b0, sq_off};

  always_comb begin
    state_d = state_q;
    pdst_d  = pdst_q;
    spec_d  = spec_q;
    store_d = store_q;
    pdv_d   = pdv_q;
    head_d  = head_q;
    tail_d  = tail_q;

    if (cmpl_valid && state_q[cmpl_tag] == ST_PEND)
      state_d[cmpl_tag] = ST_FIN;

    if (resolve_valid && resolve_ok) begin
      for (int i = 0; i < DEPTH; i++)
        if (state_q[i] != ST_FREE) spec_d[i] = 1'b0;
    end

    if (commit_fire) begin
      state_d[head_q] = ST_FREE;
      spec_d[head_q]  = 1'b0;
      store_d[head_q] = 1'b0;
      pdv_d[head_q]   = 1'b0;
      head_d          = head_q + 1'b1;
    end

    // Squash after completion so a same-cycle completion cannot resurrect a squashed entry.
    if (squash) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (((IDX_W+1)'(i) >= {1'b0, sq_off}) && ((IDX_W+1)'(i) < count_q)) begin
          state_d[head_q + IDX_W'(i)] = ST_FREE;
          spec_d[head_q + IDX_W'(i)]  = 1'b0;
          store_d[head_q + IDX_W'(i)] = 1'b0;
          pdv_d[head_q + IDX_W'(i)]   = 1'b0;
        end
      end
      tail_d = sq_idx;
    end

    if (alloc_fire) begin
      state_d[tail_q] = ST_PEND;
      spec_d[tail_q]  = alloc_spec;
      store_d[tail_q] = alloc_store;
      pdv_d[tail_q]   = alloc_pdst_v;
      pdst_d[tail_q]  = alloc_pdst;
      tail_d          = tail_q + 1'b1;
    end

    count_d = count_q + (IDX_W+1)'(alloc_fire) - (IDX_W+1)'(commit_fire)
            - (squash ? sq_num : '0);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        state_q[i] <= ST_FREE;
        pdst_q[i]  <= '0;
      end
      spec_q  <= '0;
      store_q <= '0;
      pdv_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pdst_q  <= pdst_d;
      spec_q  <= spec_d;
      store_q <= store_d;
      pdv_q   <= pdv_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule
